// File: rtl/pass_sched_pkg.sv
// Shared types and constants for the layer pass scheduler.
package pass_sched_pkg;

  // Bit of op_config that carries the one-cycle pass start strobe.
  localparam int OP_START_BIT = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } sched_state_e;

  // A layer is in progress from LOAD up to and including ADVANCE.
  function automatic logic state_is_busy(sched_state_e s);
    return (s == LOAD) || (s == ISSUE) || (s == WAIT) || (s == ADVANCE);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// One running GLB address: latched base and stride, stepped by adders only.
module tile_addr_gen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,    // capture base/stride, address <- base
  input  logic              step_i,    // address += stride
  input  logic              wrap_i,    // address <- latched base
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_q;

  // Running address register; load beats wrap beats step, sum wraps mod 2^ADDR_W.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
    end else if (load_i) begin
      base_q   <= base_i;
      stride_q <= stride_i;
      addr_q   <= base_i;
    end else if (wrap_i) begin
      addr_q   <= base_q;
    end else if (step_i) begin
      addr_q   <= addr_q + stride_q;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/layer_pass_scheduler.sv
// Walks one convolution layer as oc-tile (outer) x ic-tile (inner) passes,
// issuing each pass to the PE-array pass controller and waiting for its done.
module layer_pass_scheduler
  import pass_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] cfg_oc_tiles,
  input  logic [TILE_W-1:0] cfg_ic_tiles,
  input  logic [31:0]       cfg_op_config,
  input  logic [31:0]       cfg_mapping_param,
  input  logic [31:0]       cfg_shape_param1,
  input  logic [31:0]       cfg_shape_param2,
  input  logic [ADDR_W-1:0] cfg_filter_base,
  input  logic [ADDR_W-1:0] cfg_ifmap_base,
  input  logic [ADDR_W-1:0] cfg_bias_base,
  input  logic [ADDR_W-1:0] cfg_opsum_base,
  input  logic [ADDR_W-1:0] cfg_filter_stride,
  input  logic [ADDR_W-1:0] cfg_ifmap_stride,
  input  logic [ADDR_W-1:0] cfg_bias_stride,
  input  logic [ADDR_W-1:0] cfg_opsum_stride,
  output logic [31:0]       op_config,
  output logic [31:0]       mapping_param,
  output logic [31:0]       shape_param1,
  output logic [31:0]       shape_param2,
  output logic [ADDR_W-1:0] filter_baseaddr,
  output logic [ADDR_W-1:0] ifmap_baseaddr,
  output logic [ADDR_W-1:0] bias_baseaddr,
  output logic [ADDR_W-1:0] opsum_baseaddr,
  output logic              bias_ipsum_sel,
  input  logic              pass_done,
  output logic              busy,
  output logic              layer_done,
  output logic [TILE_W-1:0] oc_idx,
  output logic [TILE_W-1:0] ic_idx
);

  sched_state_e      state_q;
  logic [TILE_W-1:0] oc_tiles_q;
  logic [TILE_W-1:0] ic_tiles_q;
  logic [TILE_W-1:0] oc_idx_q;
  logic [TILE_W-1:0] ic_idx_q;
  logic [TILE_W-1:0] oc_idx_d;
  logic [TILE_W-1:0] ic_idx_d;
  logic [31:0]       op_cfg_q;
  logic [31:0]       mapping_q;
  logic [31:0]       shape1_q;
  logic [31:0]       shape2_q;
  logic              issue_q;
  logic              busy_q;
  logic              layer_done_q;
  logic              sel_q;

  logic              last_ic;
  logic              last_oc;
  logic              load_en;
  logic              adv_en;
  logic              ic_wrap;
  logic              zero_tiles;

  // Tile-loop bookkeeping derived from the current indices and latched counts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ic_idx_d = ic_idx_q + TILE_W'(1);
    oc_idx_d = oc_idx_q;
    if (last_ic) begin
      ic_idx_d = '0;
      oc_idx_d = oc_idx_q + TILE_W'(1);
    end
  end

  assign last_ic    = (ic_idx_q == ic_tiles_q - TILE_W'(1));
  assign last_oc    = (oc_idx_q == oc_tiles_q - TILE_W'(1));
  assign load_en    = (state_q == LOAD);
  assign adv_en     = (state_q == ADVANCE);
  assign ic_wrap    = adv_en && last_ic;
  assign zero_tiles = (cfg_oc_tiles == '0) || (cfg_ic_tiles == '0);

  // Layer sequencer: state, latched config, tile indices and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      oc_tiles_q   <= '0;
      ic_tiles_q   <= '0;
      oc_idx_q     <= '0;
      ic_idx_q     <= '0;
      op_cfg_q     <= '0;
      mapping_q    <= '0;
      shape1_q     <= '0;
      shape2_q     <= '0;
      issue_q      <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      sel_q        <= 1'b0;
    end else begin
      issue_q      <= 1'b0;
      layer_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          oc_tiles_q <= cfg_oc_tiles;
          ic_tiles_q <= cfg_ic_tiles;
          op_cfg_q   <= cfg_op_config;
          op_cfg_q[OP_START_BIT] <= 1'b0;
          mapping_q  <= cfg_mapping_param;
          shape1_q   <= cfg_shape_param1;
          shape2_q   <= cfg_shape_param2;
          oc_idx_q   <= '0;
          ic_idx_q   <= '0;
          sel_q      <= 1'b1;
          if (zero_tiles) begin
            state_q      <= DONE;
            busy_q       <= state_is_busy(DONE);
            layer_done_q <= 1'b1;
          end else begin
            state_q <= ISSUE;
            issue_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (pass_done) begin
            state_q <= ADVANCE;
          end
        end
        ADVANCE: begin
          oc_idx_q <= oc_idx_d;
          ic_idx_q <= ic_idx_d;
          sel_q    <= last_ic;
          if (last_ic && last_oc) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b1;
          end else begin
            state_q <= ISSUE;
            issue_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Filter address: one stride per pass across the whole layer.
  tile_addr_gen #(.ADDR_W(ADDR_W)) u_filter_addr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_en),
    .step_i   (adv_en),
    .wrap_i   (1'b0),
    .base_i   (cfg_filter_base),
    .stride_i (cfg_filter_stride),
    .addr_o   (filter_baseaddr)
  );

  // Ifmap address: follows the ic tile, back to base when ic wraps.
  tile_addr_gen #(.ADDR_W(ADDR_W)) u_ifmap_addr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_en),
    .step_i   (adv_en),
    .wrap_i   (ic_wrap),
    .base_i   (cfg_ifmap_base),
    .stride_i (cfg_ifmap_stride),
    .addr_o   (ifmap_baseaddr)
  );

  // Bias address: follows the oc tile.
  tile_addr_gen #(.ADDR_W(ADDR_W)) u_bias_addr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_en),
    .step_i   (ic_wrap),
    .wrap_i   (1'b0),
    .base_i   (cfg_bias_base),
    .stride_i (cfg_bias_stride),
    .addr_o   (bias_baseaddr)
  );

  // Opsum address: follows the oc tile.
  tile_addr_gen #(.ADDR_W(ADDR_W)) u_opsum_addr (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_en),
    .step_i   (ic_wrap),
    .wrap_i   (1'b0),
    .base_i   (cfg_opsum_base),
    .stride_i (cfg_opsum_stride),
    .addr_o   (opsum_baseaddr)
  );

  // Forwarded op_config with the pass start strobe merged into its low bit.
  always_comb begin
    op_config               = op_cfg_q;
    op_config[OP_START_BIT] = issue_q;
  end

  assign mapping_param  = mapping_q;
  assign shape_param1   = shape1_q;
  assign shape_param2   = shape2_q;
  assign bias_ipsum_sel = sel_q;
  assign busy           = busy_q;
  assign layer_done     = layer_done_q;
  assign oc_idx         = oc_idx_q;
  assign ic_idx         = ic_idx_q;

endmodule

// File: tb/tb_layer_pass_scheduler.sv
// Scoreboard bench for layer_pass_scheduler: the driver pushes the expected
// pass descriptors and layer_done cycles, the monitor pops on each strobe.
module tb_layer_pass_scheduler;

  localparam int ADDR_W = 32;
  localparam int TILE_W = 8;

  localparam logic [31:0] OPC = 32'hA5A5_5A5B;
  localparam logic [31:0] MAP = 32'h1234_5678;
  localparam logic [31:0] SH1 = 32'h0BAD_F00D;
  localparam logic [31:0] SH2 = 32'h0000_C0DE;

  // Hand-computed pass table for OC=2, IC=3, strides 0x40/0x80/0x10/0x10, bases 0.
  localparam logic [31:0] T2_FILT [6] = '{32'h000, 32'h040, 32'h080, 32'h0C0, 32'h100, 32'h140};
  localparam logic [31:0] T2_IFM  [6] = '{32'h000, 32'h080, 32'h100, 32'h000, 32'h080, 32'h100};
  localparam logic [31:0] T2_OCA  [6] = '{32'h000, 32'h000, 32'h000, 32'h010, 32'h010, 32'h010};
  localparam logic        T2_SEL  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0]  T2_OC   [6] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  localparam logic [7:0]  T2_IC   [6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              pass_done = 1'b0;
  logic [TILE_W-1:0] cfg_oc_tiles, cfg_ic_tiles;
  logic [31:0]       cfg_op_config, cfg_mapping_param, cfg_shape_param1, cfg_shape_param2;
  logic [ADDR_W-1:0] cfg_filter_base, cfg_ifmap_base, cfg_bias_base, cfg_opsum_base;
  logic [ADDR_W-1:0] cfg_filter_stride, cfg_ifmap_stride, cfg_bias_stride, cfg_opsum_stride;
  logic [31:0]       op_config, mapping_param, shape_param1, shape_param2;
  logic [ADDR_W-1:0] filter_baseaddr, ifmap_baseaddr, bias_baseaddr, opsum_baseaddr;
  logic              bias_ipsum_sel, busy, layer_done;
  logic [TILE_W-1:0] oc_idx, ic_idx;

  typedef struct {
    logic [31:0] filt;
    logic [31:0] ifm;
    logic [31:0] bias;
    logic [31:0] ops;
    logic        sel;
    logic [7:0]  oc;
    logic [7:0]  ic;
    int          cyc;
  } pass_t;

  pass_t exp_q[$];
  int    done_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  layer_pass_scheduler #(.ADDR_W(ADDR_W), .TILE_W(TILE_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_oc_tiles      (cfg_oc_tiles),
    .cfg_ic_tiles      (cfg_ic_tiles),
    .cfg_op_config     (cfg_op_config),
    .cfg_mapping_param (cfg_mapping_param),
    .cfg_shape_param1  (cfg_shape_param1),
    .cfg_shape_param2  (cfg_shape_param2),
    .cfg_filter_base   (cfg_filter_base),
    .cfg_ifmap_base    (cfg_ifmap_base),
    .cfg_bias_base     (cfg_bias_base),
    .cfg_opsum_base    (cfg_opsum_base),
    .cfg_filter_stride (cfg_filter_stride),
    .cfg_ifmap_stride  (cfg_ifmap_stride),
    .cfg_bias_stride   (cfg_bias_stride),
    .cfg_opsum_stride  (cfg_opsum_stride),
    .op_config         (op_config),
    .mapping_param     (mapping_param),
    .shape_param1      (shape_param1),
    .shape_param2      (shape_param2),
    .filter_baseaddr   (filter_baseaddr),
    .ifmap_baseaddr    (ifmap_baseaddr),
    .bias_baseaddr     (bias_baseaddr),
    .opsum_baseaddr    (opsum_baseaddr),
    .bias_ipsum_sel    (bias_ipsum_sel),
    .pass_done         (pass_done),
    .busy              (busy),
    .layer_done        (layer_done),
    .oc_idx            (oc_idx),
    .ic_idx            (ic_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic set_cfg(input logic [7:0] oc, input logic [7:0] ic,
                         input logic [31:0] fb, input logic [31:0] ib,
                         input logic [31:0] bb, input logic [31:0] ob,
                         input logic [31:0] fs, input logic [31:0] is,
                         input logic [31:0] bs, input logic [31:0] os);
    cfg_oc_tiles = oc;        cfg_ic_tiles = ic;
    cfg_filter_base = fb;     cfg_ifmap_base = ib;
    cfg_bias_base = bb;       cfg_opsum_base = ob;
    cfg_filter_stride = fs;   cfg_ifmap_stride = is;
    cfg_bias_stride = bs;     cfg_opsum_stride = os;
    cfg_op_config = OPC;      cfg_mapping_param = MAP;
    cfg_shape_param1 = SH1;   cfg_shape_param2 = SH2;
  endtask

  task automatic scramble_cfg();
    set_cfg(8'd7, 8'd5, 32'hDEAD_0000, 32'hBEEF_0000, 32'hCAFE_0000, 32'hF00D_0000,
            32'h4, 32'h8, 32'hC, 32'h10);
    cfg_op_config = 32'h0F0F_0F0F;
    cfg_mapping_param = 32'hFFFF_FFFF;
    cfg_shape_param1 = 32'h1111_1111;
    cfg_shape_param2 = 32'h2222_2222;
  endtask

  // Table 1 is the single-pass layer, table 2 the 2x3 layer.
  function automatic pass_t exp_pass(input int tbl, input int p, input int c);
    pass_t e;
    if (tbl == 1) begin
      e.filt = 32'h0; e.ifm = 32'h1000; e.bias = 32'h2000; e.ops = 32'h3000;
      e.sel = 1'b1;   e.oc = 8'd0;      e.ic = 8'd0;
    end else begin
      e.filt = T2_FILT[p]; e.ifm = T2_IFM[p]; e.bias = T2_OCA[p]; e.ops = T2_OCA[p];
      e.sel = T2_SEL[p];   e.oc = T2_OC[p];   e.ic = T2_IC[p];
    end
    e.cyc = c;
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_op_config"}, 64'(op_config), 64'h0);
    check({tag, "_mapping"},   64'(mapping_param), 64'h0);
    check({tag, "_shape"},     {shape_param1, shape_param2}, 64'h0);
    check({tag, "_filt_ifm"},  {filter_baseaddr, ifmap_baseaddr}, 64'h0);
    check({tag, "_bias_ops"},  {bias_baseaddr, opsum_baseaddr}, 64'h0);
    check({tag, "_sel_busy_done"}, 64'({bias_ipsum_sel, busy, layer_done}), 64'h0);
    check({tag, "_idx"},       64'({oc_idx, ic_idx}), 64'h0);
  endtask

  // Monitor: compare every issued pass and every layer_done against the queues.
  always @(negedge clk) begin
    pass_t e;
    int    dc;
    if (!rst) begin
      if (op_config[0]) begin
        if (exp_q.size() == 0) begin
          fail_event("unexpected_pass", "issue pulse seen, required none");
        end else begin
          e = exp_q.pop_front();
          check("pass_cycle",  64'(cyc), 64'(e.cyc));
          check("pass_filt",   64'(filter_baseaddr), 64'(e.filt));
          check("pass_ifmap",  64'(ifmap_baseaddr), 64'(e.ifm));
          check("pass_bias",   64'(bias_baseaddr), 64'(e.bias));
          check("pass_opsum",  64'(opsum_baseaddr), 64'(e.ops));
          check("pass_sel",    64'(bias_ipsum_sel), 64'(e.sel));
          check("pass_idx",    64'({oc_idx, ic_idx}), 64'({e.oc, e.ic}));
          check("pass_opcfg",  64'(op_config), 64'(OPC));
          check("pass_params", {mapping_param, shape_param1 ^ shape_param2}, {MAP, SH1 ^ SH2});
          check("pass_busy",   64'(busy), 64'h1);
        end
      end
      if (layer_done) begin
        if (done_q.size() == 0) begin
          fail_event("unexpected_layer_done", "layer_done seen, required none");
        end else begin
          dc = done_q.pop_front();
          check("layer_done_cycle", 64'(cyc), 64'(dc));
          check("layer_done_busy",  64'(busy), 64'h0);
        end
      end
    end
  end

  task automatic drain(input string tag);
    int k = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) fail_event({tag, "_drain_timeout"}, "expected strobes still pending after 20 cycles");
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(busy), 64'h0);
  endtask

  task automatic run_layer(input int tbl, input int n, input int rst_pass,
                           input bit chg, input bit spur);
    int k;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(exp_pass(tbl, 0, cyc + 2));
    @(negedge clk);                   // LOAD
    start = spur;
    pass_done = spur;
    for (int p = 0; p < n; p++) begin
      k = 0;
      while (!op_config[0] && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) begin
        fail_event("issue_timeout", "no issue pulse within 50 cycles");
        start = 1'b0;
        pass_done = 1'b0;
        return;
      end
      pass_done = (p == 0) && spur;   // ISSUE
      @(negedge clk);
      start = 1'b0;
      pass_done = 1'b0;
      if (chg && p == 1) scramble_cfg();
      repeat (2) @(negedge clk);
      if (p == 0 && spur) begin
        check("spur_busy",   64'(busy), 64'h1);
        check("spur_opcfg",  64'(op_config), 64'(OPC & 32'hFFFF_FFFE));
        check("spur_idx",    64'({oc_idx, ic_idx}), 64'h0);
        check("spur_addr_a", {filter_baseaddr, ifmap_baseaddr}, {32'h0, 32'h1000});
        check("spur_addr_b", {bias_baseaddr, opsum_baseaddr}, {32'h2000, 32'h3000});
        check("spur_sel",    64'(bias_ipsum_sel), 64'h1);
      end
      if (p == rst_pass) begin
        rst = 1'b1;
        pass_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pass_done = 1'b0;
        check_all_zero("midrst");
        repeat (5) @(negedge clk);
        check("midrst_still_idle", 64'(busy), 64'h0);
        return;
      end
      pass_done = 1'b1;
      if (p < n - 1) exp_q.push_back(exp_pass(tbl, p + 1, cyc + 2));
      else done_q.push_back(cyc + 2);
      @(negedge clk);
      pass_done = 1'b0;
    end
    drain("layer");
  endtask

  task automatic run_zero();
    @(negedge clk);
    start = 1'b1;
    done_q.push_back(cyc + 2);
    @(negedge clk);
    start = 1'b0;
    drain("zero");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_cfg(8'd1, 8'd1, 32'h0, 32'h1000, 32'h2000, 32'h3000,
            32'h100, 32'h100, 32'h100, 32'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single pass with spurious pass_done and repeated start around LOAD/ISSUE.
    run_layer(1, 1, -1, 1'b0, 1'b1);

    // 2x3 layer, six passes in order.
    set_cfg(8'd2, 8'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h80, 32'h10, 32'h10);
    run_layer(2, 6, -1, 1'b0, 1'b0);

    // Zero input-channel tiles: no pass, layer_done two cycles after start.
    set_cfg(8'd2, 8'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h80, 32'h10, 32'h10);
    run_zero();

    // Reset while waiting on pass 3, then a fresh layer with cfg churn mid-layer.
    set_cfg(8'd2, 8'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h80, 32'h10, 32'h10);
    run_layer(2, 6, 3, 1'b0, 1'b0);
    run_layer(2, 6, -1, 1'b1, 1'b0);

    check("final_pass_queue", 64'(exp_q.size()), 64'h0);
    check("final_done_queue", 64'(done_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/layer_pass_scheduler.md
# layer_pass_scheduler

Sequences one convolution layer as a series of processing passes on the PE-array pass controller. The layer is tiled into output-channel tiles (outer loop) and input-channel tiles (inner loop). For each pass the block computes GLB base addresses and selects bias or ipsum as the partial-sum source. It then issues a one-cycle start on `op_config[0]` and waits for the pass controller's `done` before advancing. It sits between the CPU-visible layer config registers and the pass controller.

## Interface
- `ADDR_W`, 32, width of all GLB byte addresses and strides
- `TILE_W`, 8, width of tile counts and tile indices
---
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: layer start pulse, honoured only in IDLE
- `cfg_oc_tiles`, `cfg_ic_tiles` in TILE_W: number of output-channel and input-channel tiles
- `cfg_op_config` in 32: bits [31:1] forwarded; bit 0 ignored
- `cfg_mapping_param`, `cfg_shape_param1`, `cfg_shape_param2` in 32: forwarded unchanged
- `cfg_filter_base`, `cfg_ifmap_base`, `cfg_bias_base`, `cfg_opsum_base` in ADDR_W: layer base addresses
- `cfg_filter_stride` in ADDR_W: filter bytes per (oc, ic) tile
- `cfg_ifmap_stride` in ADDR_W: ifmap bytes per ic tile
- `cfg_bias_stride` in ADDR_W: bias bytes per oc tile
- `cfg_opsum_stride` in ADDR_W: opsum bytes per oc tile
- `op_config` out 32: {latched cfg_op_config[31:1], start pulse}
- `mapping_param`, `shape_param1`, `shape_param2` out 32: latched copies
- `filter_baseaddr`, `ifmap_baseaddr`, `bias_baseaddr`, `opsum_baseaddr` out ADDR_W: per-pass addresses
- `bias_ipsum_sel` out 1: 1 = read bias (first ic tile), 0 = read ipsum from opsum
- `pass_done` in 1: `done` pulse from the pass controller
- `busy` out 1: layer in progress
- `layer_done` out 1: one-cycle pulse at the end of the layer
- `oc_idx`, `ic_idx` out TILE_W: indices of the current pass

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → ISSUE.
  - LOAD → DONE instead, if either tile count is 0.
  - ISSUE → WAIT.
  - WAIT → ADVANCE on `pass_done`.
  - ADVANCE → ISSUE, or → DONE if that was the last pass.
  - DONE → IDLE.
- LOAD:
  - Latches all `cfg_*` inputs; `cfg_*` changes after LOAD have no effect until the next layer.
  - Clears `oc_idx` and `ic_idx`.
  - Sets the running addresses to the bases.
- ISSUE: `op_config[0]`=1 for exactly this cycle.
- Per-pass addresses are built incrementally with adders; no multipliers.
  - `filter_baseaddr` = base + (oc·IC + ic)·filter_stride. It advances by one filter_stride on every ADVANCE, so it never resets.
  - `ifmap_baseaddr` = base + ic·ifmap_stride. It resets to base when ic wraps.
  - `bias_baseaddr` = base + oc·bias_stride.
  - `opsum_baseaddr` = base + oc·opsum_stride.
  - Bias and opsum addresses advance only when ic wraps.
- `bias_ipsum_sel` = (ic_idx == 0).
- ADVANCE:
  - If ic_idx == IC−1: ic_idx ← 0 and oc_idx ← oc_idx+1.
  - Otherwise: ic_idx ← ic_idx+1.
  - Last pass: oc_idx == OC−1 and ic_idx == IC−1.
- Address arithmetic wraps modulo 2^ADDR_W silently.
- `pass_done` outside WAIT is ignored.
- `start` while `busy` is ignored.
- `busy` = 1 in LOAD, ISSUE, WAIT and ADVANCE; 0 in IDLE and DONE.
- Address, index and `bias_ipsum_sel` outputs hold their values from ISSUE through WAIT. The pass controller samples them only during its own pass.

## Timing
- Reset values: state IDLE; every output 0, including the latched params, addresses, indices, `layer_done` and `busy`.
- `rst` mid-layer returns to IDLE on the next edge. Any in-flight `pass_done` is lost.
- Start latency: `start` sampled in cycle N → LOAD in N+1 → `op_config[0]` high in N+2.
- Pass-to-pass latency: `pass_done` sampled in cycle M → ADVANCE in M+1 → next ISSUE pulse in M+2.
- After the last pass: ADVANCE in M+1 → `layer_done` high in M+2 → IDLE in M+3. A new `start` is accepted in cycle M+3.
- Zero tile count: `layer_done` pulses 2 cycles after `start`; no pass is issued.
- All outputs are registered.

## Structure
- Shared package `pass_sched_pkg`:
  - State enum `sched_state_e` (IDLE, LOAD, ISSUE, WAIT, ADVANCE, DONE).
  - `OP_START_BIT` = 0.
- Sub-module `tile_addr_gen`:
  - Holds one running address.
  - Controls: `load` (← base), `step` (+= stride), `wrap` (← base).
  - Instantiated four times.
- FSM and tile counters live in the top module.

## Test plan
- OC=1, IC=1, all strides 0x100, bases 0x0/0x1000/0x2000/0x3000:
  - exactly one `op_config[0]` pulse with `bias_ipsum_sel`=1;
  - `pass_done` → `layer_done` 2 cycles later.
- OC=2, IC=3, filter stride 0x40, ifmap stride 0x80, bias/opsum stride 0x10, bases 0:
  - 6 passes in order;
  - `filter_baseaddr` 0,0x40,…,0x140;
  - `ifmap_baseaddr` 0,0x80,0x100 repeating;
  - `bias_ipsum_sel` 1,0,0,1,0,0;
  - `opsum_baseaddr` 0,0,0,0x10,0x10,0x10.
- Spurious `pass_done` during LOAD/ISSUE and repeated `start` while busy → no state, index or address change.
- `cfg_ic_tiles`=0 → no `op_config[0]` pulse; `layer_done` exactly 2 cycles after `start`.
- `rst` asserted in WAIT of pass 3 → next cycle all outputs 0 and state IDLE; a fresh layer then runs from pass 0.
- `cfg_*` changed mid-layer → outputs keep the values latched at LOAD.
